// File: rtl/ipv4_rx.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_rx
// Brief    : IPv4 header parser/filter on a 16-bit MAC RX stream; forwards UDP payload.
// Revision : 1.0
// ============================================================================
module ipv4_rx #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              term_i,
    input  logic [31:0]       ip_addr_i,
    output logic              valid_o,
    output logic              start_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              term_o,
    output logic [31:0]       src_addr_o,
    output logic              cancel_o,
    output logic              hdr_err_o,
    output logic              len_err_o
);
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        HEAD = 4'b0010,
        DATA = 4'b0100,
        DROP = 4'b1000
    } state_t;

    state_t      state;
    logic [4:0]  word_cnt;
    logic [4:0]  last_word;
    logic [3:0]  ihl;
    logic [15:0] total_len;
    logic [15:0] csum;
    logic [15:0] remaining;
    logic        hdr_bad;
    logic        first_beat;
    logic [31:0] src_hold;

    logic [15:0] swapped;
    logic [16:0] sum_raw;
    logic [15:0] csum_next;
    logic [15:0] hdr_bytes;
    logic        field_bad;
    logic        start_ok;
    logic [15:0] len_in;
    logic        last_payload;
    logic [15:0] take;

    // Header words are big-endian on the wire, so swap to network order before use.
    always_comb begin
        swapped      = {data_i[7:0], data_i[15:8]};
        sum_raw      = {1'b0, csum} + {1'b0, swapped};
        csum_next    = sum_raw[15:0] + {15'd0, sum_raw[16]};
        hdr_bytes    = {10'd0, ihl, 2'b00};
        start_ok     = (data_i[7:4] == 4'd4) && (data_i[3:0] >= 4'd5);
        len_in       = 16'(len_i);
        last_payload = (remaining <= len_in);
        take         = last_payload ? remaining : len_in;
        field_bad    = 1'b0;
        case (word_cnt)
            5'd1:    field_bad = (swapped < hdr_bytes);
            5'd3:    field_bad = data_i[5] || ({data_i[4:0], data_i[15:8]} != 13'd0);
            5'd4:    field_bad = (data_i[15:8] != 8'h11);
            5'd8:    field_bad = (swapped != ip_addr_i[31:16]);
            5'd9:    field_bad = (swapped != ip_addr_i[15:0]);
            default: field_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            word_cnt   <= 5'd0;
            last_word  <= 5'd0;
            ihl        <= 4'd0;
            total_len  <= 16'd0;
            csum       <= 16'd0;
            remaining  <= 16'd0;
            hdr_bad    <= 1'b0;
            first_beat <= 1'b0;
            src_hold   <= 32'd0;
            valid_o    <= 1'b0;
            start_o    <= 1'b0;
            data_o     <= '0;
            len_o      <= '0;
            term_o     <= 1'b0;
            src_addr_o <= 32'd0;
            cancel_o   <= 1'b0;
            hdr_err_o  <= 1'b0;
            len_err_o  <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            start_o   <= 1'b0;
            term_o    <= 1'b0;
            cancel_o  <= 1'b0;
            hdr_err_o <= 1'b0;
            len_err_o <= 1'b0;
            if (cancel_i) begin
                state    <= IDLE;
                cancel_o <= (state == DATA);
            end else if (valid_i && start_i) begin
                cancel_o  <= (state == DATA);
                word_cnt  <= 5'd1;
                ihl       <= data_i[3:0];
                // A bad IHL still consumes a minimal header so the frame is flushed predictably.
                last_word <= (data_i[3:0] < 4'd5) ? 5'd9 : ({data_i[3:0], 1'b0} - 5'd1);
                csum      <= swapped;
                hdr_bad   <= !start_ok;
                if (term_i) begin
                    state     <= IDLE;
                    hdr_err_o <= 1'b1;
                end else begin
                    state <= HEAD;
                end
            end else if (valid_i) begin
                case (state)
                    HEAD: begin
                        word_cnt <= word_cnt + 5'd1;
                        csum     <= csum_next;
                        hdr_bad  <= hdr_bad | field_bad;
                        if (word_cnt == 5'd1) total_len <= swapped;
                        if (word_cnt == 5'd6) src_hold[31:16] <= swapped;
                        if (word_cnt == 5'd7) src_hold[15:0] <= swapped;
                        if (term_i) begin
                            state     <= IDLE;
                            hdr_err_o <= 1'b1;
                        end else if (word_cnt == last_word) begin
                            if (hdr_bad || field_bad || (csum_next != 16'hFFFF)) begin
                                state     <= DROP;
                                hdr_err_o <= 1'b1;
                            end else begin
                                state      <= DATA;
                                remaining  <= total_len - hdr_bytes;
                                first_beat <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (remaining == 16'd0) begin
                            state <= term_i ? IDLE : DROP;
                        end else begin
                            valid_o    <= 1'b1;
                            start_o    <= first_beat;
                            first_beat <= 1'b0;
                            data_o     <= data_i;
                            len_o      <= take[LEN_W-1:0];
                            remaining  <= remaining - take;
                            if (first_beat) src_addr_o <= src_hold;
                            if (last_payload) begin
                                term_o <= 1'b1;
                                state  <= term_i ? IDLE : DROP;
                            end else if (term_i) begin
                                term_o    <= 1'b1;
                                len_err_o <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (term_i) state <= IDLE;
                    end
                    IDLE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ipv4_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipv4_rx
// Brief    : Directed self-checking bench for ipv4_rx.
// Revision : 1.0
// ============================================================================
module tb_ipv4_rx;
    localparam int          LEN_W    = 2;
    localparam logic [31:0] LOCAL_IP = 32'hC0A80102;
    localparam logic [31:0] SRC_A    = 32'hC0A80101;
    localparam logic [31:0] SRC_B    = 32'hC0A80105;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             cancel_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             start_i = 1'b0;
    logic [15:0]      data_i = 16'd0;
    logic [LEN_W-1:0] len_i = '0;
    logic             term_i = 1'b0;
    logic [31:0]      ip_addr_i = LOCAL_IP;
    logic             valid_o, start_o, term_o, cancel_o, hdr_err_o, len_err_o;
    logic [15:0]      data_o;
    logic [LEN_W-1:0] len_o;
    logic [31:0]      src_addr_o;

    always #5 clk = ~clk;

    ipv4_rx #(.DATA_W(16), .LEN_W(LEN_W)) dut (
        .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
        .start_i(start_i), .data_i(data_i), .len_i(len_i), .term_i(term_i),
        .ip_addr_i(ip_addr_i), .valid_o(valid_o), .start_o(start_o),
        .data_o(data_o), .len_o(len_o), .term_o(term_o), .src_addr_o(src_addr_o),
        .cancel_o(cancel_o), .hdr_err_o(hdr_err_o), .len_err_o(len_err_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] frame [0:63];
    logic [7:0] out_bytes [0:63];
    int n_valid, n_start, n_term, n_hdr, n_len_err, n_cancel, n_bytes;
    int term_beat, valid_after_term, start_first, last_len, term_lenerr;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_o) begin
            if (n_term > 0) valid_after_term++;
            if (n_valid == 0) start_first = int'(start_o);
            n_valid++;
            if (start_o) n_start++;
            for (int i = 0; i < int'(len_o); i++)
                if (n_bytes + i < 64) out_bytes[n_bytes + i] = data_o[8*i +: 8];
            n_bytes += int'(len_o);
            last_len = int'(len_o);
            if (term_o) begin
                n_term++;
                term_beat = n_valid;
                if (len_err_o) term_lenerr++;
            end
        end
        if (hdr_err_o) n_hdr++;
        if (len_err_o) n_len_err++;
        if (cancel_o) n_cancel++;
    end

    task automatic clr_mon();
        n_valid = 0; n_start = 0; n_term = 0; n_hdr = 0; n_len_err = 0; n_cancel = 0;
        n_bytes = 0; term_beat = 0; valid_after_term = 0; start_first = 0; last_len = 0;
        term_lenerr = 0;
    endtask

    task automatic fix_csum(input int ihl);
        logic [31:0] sum;
        logic [15:0] c;
        frame[10] = 8'h00;
        frame[11] = 8'h00;
        sum = 32'd0;
        for (int w = 0; w < 2*ihl; w++) sum += {16'd0, frame[2*w], frame[2*w+1]};
        while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        c = ~sum[15:0];
        frame[10] = c[15:8];
        frame[11] = c[7:0];
    endtask

    task automatic build(input int ihl, input logic [15:0] tl, input logic [7:0] proto,
                         input logic [7:0] flags, input logic [31:0] src, input logic [7:0] seed);
        for (int i = 0; i < 64; i++) frame[i] = 8'h00;
        frame[0] = {4'h4, 4'(ihl)};
        frame[2] = tl[15:8];  frame[3] = tl[7:0];
        frame[5] = 8'h01;     frame[6] = flags;
        frame[8] = 8'h40;     frame[9] = proto;
        frame[12] = src[31:24]; frame[13] = src[23:16]; frame[14] = src[15:8]; frame[15] = src[7:0];
        frame[16] = LOCAL_IP[31:24]; frame[17] = LOCAL_IP[23:16];
        frame[18] = LOCAL_IP[15:8];  frame[19] = LOCAL_IP[7:0];
        for (int i = 20; i < 4*ihl; i++) frame[i] = 8'h01;
        for (int i = 4*ihl; i < int'(tl); i++) frame[i] = seed + 8'(i - 4*ihl);
        fix_csum(ihl);
    endtask

    task automatic beat(input logic [15:0] d, input int l, input logic s, input logic t, input logic c);
        valid_i = 1'b1; data_i = d; len_i = l[LEN_W-1:0]; start_i = s; term_i = t; cancel_i = c;
        @(posedge clk); #1;
        valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; cancel_i = 1'b0; len_i = '0;
    endtask

    // Sends n frame bytes; max_beats >= 0 stops early without term_i.
    task automatic send_frame(input int n, input int max_beats);
        int nb;
        int rem;
        logic [7:0] hi;
        nb = (n + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            if (max_beats >= 0 && b >= max_beats) break;
            rem = n - 2*b;
            hi  = (rem >= 2) ? frame[2*b+1] : 8'h00;
            beat({hi, frame[2*b]}, (rem >= 2) ? 2 : 1, b == 0, (max_beats < 0) && (b == nb - 1), 1'b0);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        if ({valid_o, start_o, term_o, cancel_o, hdr_err_o, len_err_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {valid_o, start_o, term_o, cancel_o, hdr_err_o, len_err_o});
        end
        checks++;
        if (len_o !== 2'd0 || src_addr_o !== 32'd0) begin
            errors++; $display("FAIL reset_len_src: got len %0d src %h expected 0 0", len_o, src_addr_o);
        end
        checks++;
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_valid_udp();
        int bad;
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hA0);
        send_frame(31, -1);
        settle();
        if (n_valid !== 6) begin errors++; $display("FAIL udp_beats: got %0d expected 6", n_valid); end
        checks++;
        if (start_first !== 1 || n_start !== 1) begin
            errors++; $display("FAIL udp_start: got first %0d count %0d expected 1 1", start_first, n_start);
        end
        checks++;
        if (n_term !== 1 || term_beat !== 6 || last_len !== 1) begin
            errors++; $display("FAIL udp_term: got count %0d beat %0d len %0d expected 1 6 1", n_term, term_beat, last_len);
        end
        checks++;
        bad = 0;
        for (int j = 0; j < 11; j++) if (out_bytes[j] !== 8'hA0 + 8'(j)) bad++;
        if (n_bytes !== 11 || bad !== 0) begin
            errors++; $display("FAIL udp_bytes: got %0d bytes %0d wrong expected 11 0", n_bytes, bad);
        end
        checks++;
        if (src_addr_o !== SRC_A) begin errors++; $display("FAIL udp_src: got %h expected %h", src_addr_o, SRC_A); end
        checks++;
        if (n_hdr !== 0 || n_len_err !== 0) begin
            errors++; $display("FAIL udp_errs: got hdr %0d len %0d expected 0 0", n_hdr, n_len_err);
        end
        checks++;
    endtask

    task automatic test_min_frame();
        clr_mon();
        build(5, 16'h0020, 8'h11, 8'h40, SRC_A, 8'hB0);
        send_frame(46, -1);
        settle();
        if (n_bytes !== 12 || n_valid !== 6) begin
            errors++; $display("FAIL min_payload: got %0d bytes %0d beats expected 12 6", n_bytes, n_valid);
        end
        checks++;
        if (n_term !== 1 || valid_after_term !== 0) begin
            errors++; $display("FAIL min_padding: got term %0d after %0d expected 1 0", n_term, valid_after_term);
        end
        checks++;
    endtask

    task automatic test_hdr_reject();
        for (int k = 0; k < 5; k++) begin
            clr_mon();
            build(5, 16'h001F, (k == 1) ? 8'h06 : 8'h11, (k == 3) ? 8'h20 : 8'h40, SRC_A, 8'hA0);
            if (k == 0) frame[11] = frame[11] ^ 8'h01;
            if (k == 2) begin frame[19] = 8'h03; fix_csum(5); end
            send_frame((k == 4) ? 12 : 31, -1);
            settle();
            if (n_hdr !== 1 || n_valid !== 0) begin
                errors++; $display("FAIL reject_case%0d: got hdr %0d valid %0d expected 1 0", k, n_hdr, n_valid);
            end
            checks++;
        end
    endtask

    task automatic test_options();
        int bad;
        clr_mon();
        build(6, 16'h0020, 8'h11, 8'h40, SRC_A, 8'hC0);
        send_frame(32, -1);
        settle();
        bad = 0;
        for (int j = 0; j < 8; j++) if (out_bytes[j] !== 8'hC0 + 8'(j)) bad++;
        if (n_bytes !== 8 || n_valid !== 4 || bad !== 0 || n_hdr !== 0) begin
            errors++; $display("FAIL opt_payload: got %0d bytes %0d beats %0d wrong hdr %0d expected 8 4 0 0",
                               n_bytes, n_valid, bad, n_hdr);
        end
        checks++;
        clr_mon();
        build(6, 16'h0020, 8'h11, 8'h40, SRC_A, 8'hC0);
        frame[20] = 8'h00;
        send_frame(32, -1);
        settle();
        if (n_hdr !== 1 || n_valid !== 0) begin
            errors++; $display("FAIL opt_csum: got hdr %0d valid %0d expected 1 0", n_hdr, n_valid);
        end
        checks++;
    endtask

    task automatic test_short_frame();
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hA0);
        send_frame(27, -1);
        settle();
        if (n_valid !== 4 || n_bytes !== 7 || last_len !== 1) begin
            errors++; $display("FAIL short_beats: got %0d beats %0d bytes len %0d expected 4 7 1", n_valid, n_bytes, last_len);
        end
        checks++;
        if (n_term !== 1 || term_lenerr !== 1 || n_len_err !== 1) begin
            errors++; $display("FAIL short_lenerr: got term %0d both %0d lenerr %0d expected 1 1 1", n_term, term_lenerr, n_len_err);
        end
        checks++;
    endtask

    task automatic test_cancel();
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hA0);
        send_frame(31, 12);
        beat({frame[25], frame[24]}, 2, 1'b0, 1'b0, 1'b1);
        for (int b = 13; b < 16; b++) beat({frame[2*b+1], frame[2*b]}, (b == 15) ? 1 : 2, 1'b0, b == 15, 1'b0);
        settle();
        if (n_cancel !== 1 || n_valid !== 2 || n_term !== 0) begin
            errors++; $display("FAIL cancel_mid: got cancel %0d valid %0d term %0d expected 1 2 0", n_cancel, n_valid, n_term);
        end
        checks++;
    endtask

    task automatic test_start_mid();
        int bad;
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hA0);
        send_frame(31, 12);
        build(5, 16'h001F, 8'h11, 8'h40, SRC_B, 8'hD0);
        send_frame(31, -1);
        settle();
        if (n_cancel !== 1 || n_valid !== 8 || n_start !== 2 || n_term !== 1) begin
            errors++; $display("FAIL restart_counts: got cancel %0d valid %0d start %0d term %0d expected 1 8 2 1",
                               n_cancel, n_valid, n_start, n_term);
        end
        checks++;
        bad = 0;
        for (int j = 0; j < 11; j++) if (out_bytes[4 + j] !== 8'hD0 + 8'(j)) bad++;
        if (n_bytes !== 15 || bad !== 0 || src_addr_o !== SRC_B) begin
            errors++; $display("FAIL restart_data: got %0d bytes %0d wrong src %h expected 15 0 %h", n_bytes, bad, src_addr_o, SRC_B);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hA0);
        send_frame(31, 12);
        if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid %b expected 1", valid_o); end
        checks++;
        #2 nreset = 1'b0;
        #1;
        if ({valid_o, start_o, term_o, cancel_o, hdr_err_o, len_err_o} !== 6'b0 || len_o !== 2'd0 || src_addr_o !== 32'd0) begin
            errors++; $display("FAIL rstmid_outputs: got flags %b len %0d src %h expected 0 0 0",
                               {valid_o, start_o, term_o, cancel_o, hdr_err_o, len_err_o}, len_o, src_addr_o);
        end
        checks++;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        clr_mon();
        build(5, 16'h001F, 8'h11, 8'h40, SRC_A, 8'hE0);
        send_frame(31, -1);
        settle();
        if (n_valid !== 6 || n_bytes !== 11 || src_addr_o !== SRC_A || n_hdr !== 0) begin
            errors++; $display("FAIL rstmid_reparse: got valid %0d bytes %0d src %h hdr %0d expected 6 11 %h 0",
                               n_valid, n_bytes, src_addr_o, n_hdr, SRC_A);
        end
        checks++;
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_valid_udp();
        test_min_frame();
        test_hdr_reject();
        test_options();
        test_short_frame();
        test_cancel();
        test_start_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
